// File: rtl/write_buffer.sv
// Store write buffer: DEPTH-entry FIFO between the D-cache and the bus, with line-match probe for read-miss refills.
// Push to empty is presented on mem_req_out next cycle; a push at full without a same-cycle ack is dropped and flagged.
module write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_req_in,
  input  logic [31:0] wb_addr_in,
  input  logic [31:0] wb_data_in,
  input  logic [3:0]  wb_byte_en_in,
  output logic        wb_full_out,
  output logic        wb_empty_out,
  input  logic [31:0] chk_addr_in,
  output logic        chk_match_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  mem_byte_en_out,
  input  logic        mem_ack_in,
  output logic        overflow_err_out
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic          push;
  logic          pop;
  logic [PW-1:0] slot_off;
  logic          chk_addr_unused;

  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  be_q   [DEPTH];

  assign wb_full_out  = (count == (PW+1)'(DEPTH));
  assign wb_empty_out = (count == '0);

  assign pop        = mem_ack_in && (state == BUSY);
  assign push       = wb_req_in && (!wb_full_out || pop);
  assign count_next = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      mem_req_out      <= 1'b0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      overflow_err_out <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count_next;
      if (wb_req_in && !push) overflow_err_out <= 1'b1;
      case (state)
        IDLE: begin
          if (!wb_empty_out || push) begin
            state       <= BUSY;
            mem_req_out <= 1'b1;
          end
        end
        BUSY: begin
          if (pop && count_next == '0) begin
            state       <= IDLE;
            mem_req_out <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage is never reset; an entry is live only while it lies inside [head, head+count).
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= wb_addr_in;
      data_q[tail] <= wb_data_in;
      be_q[tail]   <= wb_byte_en_in;
    end
  end

  assign mem_addr_out    = mem_req_out ? addr_q[head] : '0;
  assign mem_data_out    = mem_req_out ? data_q[head] : '0;
  assign mem_byte_en_out = mem_req_out ? be_q[head]   : '0;

  // Only registered entries are probed, so a same-cycle push never matches.
  always_comb begin
    chk_match_out = 1'b0;
    slot_off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PW'(i) - head;
      if (({1'b0, slot_off} < count) && (addr_q[i][31:5] == chk_addr_in[31:5]))
        chk_match_out = 1'b1;
    end
  end

  assign chk_addr_unused = ^chk_addr_in[4:0];

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: queue-based reference model compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_req_in;
  logic [31:0] wb_addr_in;
  logic [31:0] wb_data_in;
  logic [3:0]  wb_byte_en_in;
  logic        wb_full_out;
  logic        wb_empty_out;
  logic [31:0] chk_addr_in;
  logic        chk_match_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_byte_en_out;
  logic        mem_ack_in;
  logic        overflow_err_out;

  write_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_req_in       (wb_req_in),
    .wb_addr_in      (wb_addr_in),
    .wb_data_in      (wb_data_in),
    .wb_byte_en_in   (wb_byte_en_in),
    .wb_full_out     (wb_full_out),
    .wb_empty_out    (wb_empty_out),
    .chk_addr_in     (chk_addr_in),
    .chk_match_out   (chk_match_out),
    .mem_req_out     (mem_req_out),
    .mem_addr_out    (mem_addr_out),
    .mem_data_out    (mem_data_out),
    .mem_byte_en_out (mem_byte_en_out),
    .mem_ack_in      (mem_ack_in),
    .overflow_err_out(overflow_err_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] seen[$];
  bit          m_ovf    = 1'b0;
  bit          model_ok = 1'b0;
  bit          m_pop, m_push, m_match;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  // Reference: the buffer is a bounded queue; a request is outstanding whenever the queue is non-empty.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf    = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_pop  = mem_ack_in && (mq.size() != 0);
      m_push = wb_req_in && ((mq.size() < DEPTH) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{wb_addr_in, wb_data_in, wb_byte_en_in});
      if (wb_req_in && !m_push) m_ovf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      m_match = 1'b0;
      foreach (mq[i]) if (mq[i].a[31:5] == chk_addr_in[31:5]) m_match = 1'b1;
      check("m_req",   32'(mem_req_out),      32'(mq.size() != 0));
      check("m_full",  32'(wb_full_out),      32'(mq.size() == DEPTH));
      check("m_empty", 32'(wb_empty_out),     32'(mq.size() == 0));
      check("m_ovf",   32'(overflow_err_out), 32'(m_ovf));
      check("m_match", 32'(chk_match_out),    32'(m_match));
      check("m_addr",  mem_addr_out,          (mq.size() != 0) ? mq[0].a : 32'h0);
      check("m_data",  mem_data_out,          (mq.size() != 0) ? mq[0].d : 32'h0);
      check("m_be",    32'(mem_byte_en_out),  (mq.size() != 0) ? 32'(mq[0].be) : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic req, input logic [31:0] a, input logic ack);
    wb_req_in     = req;
    wb_addr_in    = a;
    wb_data_in    = ~a;
    wb_byte_en_in = a[8:5];
    mem_ack_in    = ack;
    if (ack) seen.push_back(mem_addr_out);
    tick();
    wb_req_in  = 1'b0;
    mem_ack_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_req_in = 1'b0; wb_addr_in = '0; wb_data_in = '0;
    wb_byte_en_in = '0; chk_addr_in = '0; mem_ack_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_req",   32'(mem_req_out),      0);
    check("rst_empty", 32'(wb_empty_out),     1);
    check("rst_full",  32'(wb_full_out),      0);
    check("rst_ovf",   32'(overflow_err_out), 0);
    check("rst_match", 32'(chk_match_out),    0);
    check("rst_addr",  mem_addr_out,          0);

    // Single store, acked in cycle 3
    wb_req_in = 1'b1; wb_addr_in = 32'h0000_1004; wb_data_in = 32'hDEAD_BEEF; wb_byte_en_in = 4'hF;
    tick();
    wb_req_in = 1'b0;
    check("sgl_req",  32'(mem_req_out),     1);
    check("sgl_addr", mem_addr_out,         32'h0000_1004);
    check("sgl_data", mem_data_out,         32'hDEAD_BEEF);
    check("sgl_be",   32'(mem_byte_en_out), 32'hF);
    tick(); tick();
    check("sgl_hold", mem_addr_out, 32'h0000_1004);
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    check("sgl_empty",  32'(wb_empty_out), 1);
    check("sgl_reqlow", 32'(mem_req_out),  0);
    check("sgl_zero",   mem_data_out,      0);

    // Fill, overflow, then push at full with concurrent ack
    for (int k = 0; k < 4; k++) step(1'b1, 32'h3000 + 32'(k) * 32, 1'b0);
    check("fill_full", 32'(wb_full_out),      1);
    check("fill_ovf",  32'(overflow_err_out), 0);
    check("fill_be0",  32'(mem_byte_en_out),  0);
    step(1'b1, 32'h4000, 1'b0);
    check("ovf_flag", 32'(overflow_err_out), 1);
    check("ovf_full", 32'(wb_full_out),      1);
    step(1'b1, 32'h5000, 1'b1);
    check("cc_full", 32'(wb_full_out), 1);
    check("cc_head", mem_addr_out,     32'h3020);
    repeat (4) step(1'b0, 32'h0, 1'b1);
    check("cc_drained", 32'(wb_empty_out), 1);

    // Order across pointer wrap
    do_reset();
    seen.delete();
    for (int k = 0; k < 4; k++) step(1'b1, 32'hA000 + 32'(k) * 32'h100, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hA400, 1'b1);
    step(1'b1, 32'hA500, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b1);
    check("ord_count", 32'(seen.size()), 6);
    for (int k = 0; k < 6; k++)
      if (k < seen.size()) check("ord_addr", seen[k], 32'hA000 + 32'(k) * 32'h100);
    check("ord_empty", 32'(wb_empty_out), 1);

    // Line match probe
    do_reset();
    wb_req_in = 1'b1; wb_addr_in = 32'h0000_2010; wb_data_in = 32'h1; wb_byte_en_in = 4'h3;
    chk_addr_in = 32'h0000_2018;
    #1 check("lm_same_cycle", 32'(chk_match_out), 0);
    tick();
    wb_req_in = 1'b0;
    chk_addr_in = 32'h0000_201C;
    #1 check("lm_hit", 32'(chk_match_out), 1);
    chk_addr_in = 32'h0000_2020;
    #1 check("lm_miss", 32'(chk_match_out), 0);
    chk_addr_in = 32'h0000_201C;
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    check("lm_after_pop", 32'(chk_match_out), 0);

    // Reset mid-drain with an ack in the reset cycle
    for (int k = 0; k < 3; k++) step(1'b1, 32'h6000 + 32'(k) * 32, 1'b0);
    check("mr_busy", 32'(mem_req_out), 1);
    rst = 1'b1; mem_ack_in = 1'b1;
    tick();
    rst = 1'b0; mem_ack_in = 1'b0;
    check("mr_req",   32'(mem_req_out),  0);
    check("mr_empty", 32'(wb_empty_out), 1);
    step(1'b0, 32'h0, 1'b1);
    check("mr_ign_req",   32'(mem_req_out),  0);
    check("mr_ign_empty", 32'(wb_empty_out), 1);

    // Random traffic against the model
    repeat (3000) begin
      wb_req_in     = 1'($urandom_range(0, 1));
      wb_addr_in    = {24'h0, 3'($urandom_range(0, 7)), 5'($urandom)};
      wb_data_in    = $urandom;
      wb_byte_en_in = 4'($urandom);
      mem_ack_in    = ($urandom_range(0, 9) < 4);
      chk_addr_in   = {24'h0, 3'($urandom_range(0, 7)), 5'($urandom)};
      rst           = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; wb_req_in = 1'b0; mem_ack_in = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Clock/reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameter SHALL be: DEPTH, default 4, number of entries (power of two, >=2).
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 wb_req_in  in  1  push request from D-cache controller.
REQ-006 wb_addr_in  in  32  store byte address.
REQ-007 wb_data_in  in  32  store word, lane-aligned.
REQ-008 wb_byte_en_in  in  4  byte lane enables.
REQ-009 wb_full_out  out  1  high when count == DEPTH.
REQ-010 wb_empty_out  out  1  high when count == 0.
REQ-011 chk_addr_in  in  32  address probed by the D-cache before a read-miss refill.
REQ-012 chk_match_out  out  1  some valid entry has the same 32-byte line, addr[31:5].
REQ-013 mem_req_out  out  1  drain request to the bus arbiter.
REQ-014 mem_addr_out, mem_data_out, mem_byte_en_out  out  32/32/4  head entry fields.
REQ-015 mem_ack_in  in  1  arbiter completed the current write, one-cycle pulse.
REQ-016 overflow_err_out  out  1  sticky flag: a push was dropped.

Function
REQ-017 Storage SHALL be a circular FIFO of DEPTH entries {addr, data, byte_en}, with head/tail pointers and a count of width log2(DEPTH)+1.
REQ-018 Pointers SHALL wrap modulo DEPTH.
REQ-019 push = wb_req_in && (!full || pop); pop = mem_ack_in && state==BUSY.
REQ-020 Push at full with no pop in the same cycle SHALL be dropped, set overflow_err_out, and leave count unchanged.
REQ-021 Simultaneous push and pop SHALL keep count unchanged and advance both pointers.
REQ-022 This includes the full case (push accepted) and the count==1 case.
REQ-023 An entry with byte_en == 0 SHALL be accepted and drained like any other.
REQ-024 Drain FSM states: IDLE, BUSY.
REQ-025 IDLE -> BUSY when count != 0 or push; otherwise stay IDLE.
REQ-026 BUSY -> IDLE on pop when count_next == 0; otherwise stay BUSY.
REQ-027 mem_req_out SHALL equal (state == BUSY), registered, with no combinational path from mem_ack_in.
REQ-028 In BUSY, mem_addr/data/byte_en_out SHALL present entry[head] and hold stable until mem_ack_in.
REQ-029 After a pop, the next head SHALL be presented in the following cycle with mem_req_out still high.
REQ-030 When mem_req_out is low, mem_addr/data/byte_en_out SHALL be 0.
REQ-031 mem_ack_in while IDLE SHALL be ignored.
REQ-032 Latency: a push into an empty, IDLE buffer in cycle N SHALL give mem_req_out = 1 in cycle N+1.
REQ-033 Minimum throughput SHALL be one entry drained per ack cycle.
REQ-034 Ordering SHALL be strict FIFO, with no coalescing or reordering.
REQ-035 chk_match_out SHALL be combinational over entries currently valid, including the head being drained.
REQ-036 chk_match_out SHALL exclude a same-cycle incoming push and SHALL clear the cycle after the matching entry is popped.
REQ-037 wb_full_out and wb_empty_out SHALL be derived from the registered count only.

Reset
REQ-038 While rst is high, next edge: count=0, head=tail=0, state=IDLE, overflow_err_out=0.
REQ-039 Resulting outputs: mem_req_out=0, mem_* outputs=0, wb_full_out=0, wb_empty_out=1, chk_match_out=0.
REQ-040 Entry storage SHALL NOT be reset; validity comes from count only.
REQ-041 Reset mid-drain SHALL discard all entries and deassert mem_req_out the cycle after rst is sampled.
REQ-042 A mem_ack_in arriving in the reset cycle SHALL be ignored.
REQ-043 Reset SHALL take priority over push and pop.

Verification
REQ-044 Single store: push addr=0x0000_1004, data=0xDEAD_BEEF, be=4'hF in cycle 0 -> mem_req_out=1 in cycle 1 with those values; ack in cycle 3 -> wb_empty_out=1 and mem_req_out=0 in cycle 4.
REQ-045 Fill and overflow: 4 pushes, no ack -> wb_full_out=1; a 5th push without ack -> dropped, overflow_err_out=1, count stays 4.
REQ-046 Full with concurrent traffic: a 5th push with mem_ack_in in the same cycle -> accepted, count stays 4, wb_full_out stays 1.
REQ-047 Order and wrap: 6 pushes A..F interleaved with acks so pointers wrap -> arbiter sees A,B,C,D,E,F in order, with fields unchanged while awaiting ack.
REQ-048 Line match: entry addr 0x0000_2010 pending, chk_addr_in=0x0000_201C -> chk_match_out=1; chk_addr_in=0x0000_2020 -> chk_match_out=0; after its pop -> 0.
REQ-049 Reset mid-drain: 3 entries, rst=1 while mem_req_out=1 -> next cycle mem_req_out=0, wb_empty_out=1; a later ack -> ignored.
